// File: rtl/ifu_iccm_acc_ctl.sv
// ifu_iccm_acc_ctl -- ICCM access controller.
//
// Accepts one read or write request at a time and turns it into ICCM
// read/write enable sequences. Byte and half-word writes are done as a
// read-modify-write on the containing 32-bit word. Every 32-bit word that is
// written carries a 7-bit SECDED code.
//
// Optional feature: define ICCM_ACC_ECC_CHECK_EN to check and correct the ECC
// of every word read back from the ICCM. When it is undefined the stored ECC
// bits are ignored on reads, but writes still generate ECC.
//
// Ports:
//   clk, rst_l        clock, asynchronous active-low reset
//   req_*             request channel (valid/ready, write, byte addr, size, wdata)
//   rsp_*             response channel (valid/ready, rdata, err)
//   iccm_wren/rden    ICCM write / read enables (never both high)
//   iccm_rw_addr      ICCM word address (byte address [ICCM_BITS-1:2])
//   iccm_wr_size      ICCM write size (2 = word, 3 = dword)
//   iccm_wr_data      {odd word, even word}, each {ecc[6:0], data[31:0]}
//   iccm_rd_data      four 39-bit words, valid the cycle after a read enable
module ifu_iccm_acc_ctl #(
    parameter int unsigned ICCM_BITS = 16
) (
    input  logic                 clk,
    input  logic                 rst_l,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_write,
    input  logic [ICCM_BITS-1:0] req_addr,
    input  logic [2:0]           req_size,
    input  logic [63:0]          req_wdata,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [63:0]          rsp_rdata,
    output logic                 rsp_err,
    output logic                 iccm_wren,
    output logic                 iccm_rden,
    output logic [ICCM_BITS-3:0] iccm_rw_addr,
    output logic [2:0]           iccm_wr_size,
    output logic [77:0]          iccm_wr_data,
    input  logic [155:0]         iccm_rd_data
);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] RD      = 3'd1;
    localparam logic [2:0] RMW_RD  = 3'd2;
    localparam logic [2:0] RMW_MRG = 3'd3;
    localparam logic [2:0] WR      = 3'd4;
    localparam logic [2:0] RSP     = 3'd5;

    // Hamming code: data bits occupy the non-power-of-two positions 3..38,
    // ecc[i] covers positions with bit i set, ecc[6] is overall parity.
    function automatic logic [6:0] ecc_gen(input logic [31:0] d);
        logic [6:0] e;
        logic [4:0] j;
        e = '0;
        j = '0;
        for (int unsigned pos = 1; pos < 39; pos++) begin
            if ((pos & (pos - 1)) != 0) begin
                for (int unsigned i = 0; i < 6; i++) begin
                    if (pos[i[4:0]]) e[i[2:0]] = e[i[2:0]] ^ d[j];
                end
                j = j + 5'd1;
            end
        end
        e[6] = ^{e[5:0], d};
        return e;
    endfunction

`ifdef ICCM_ACC_ECC_CHECK_EN
    // Returns {double_error, corrected_data}.
    function automatic logic [32:0] ecc_fix(input logic [38:0] w);
        logic [5:0]  s;
        logic [31:0] d;
        logic [4:0]  j;
        logic        p;
        d = w[31:0];
        s = w[37:32];
        j = '0;
        for (int unsigned pos = 1; pos < 39; pos++) begin
            if ((pos & (pos - 1)) != 0) begin
                for (int unsigned i = 0; i < 6; i++) begin
                    if (pos[i[4:0]]) s[i[2:0]] = s[i[2:0]] ^ d[j];
                end
                j = j + 5'd1;
            end
        end
        p = ^w;
        // Odd parity means a single flip; the syndrome names its position.
        if (p) begin
            j = '0;
            for (int unsigned pos = 1; pos < 39; pos++) begin
                if ((pos & (pos - 1)) != 0) begin
                    if (pos[5:0] == s) d[j] = ~d[j];
                    j = j + 5'd1;
                end
            end
        end
        return {(s != 6'd0) && !p, d};
    endfunction
`endif

    logic [2:0]           state_q, state_d;
    logic                 arm_q;
    logic [ICCM_BITS-1:0] addr_q;
    logic [2:0]           size_q;
    logic [15:0]          wdata_q;
    logic [63:0]          rdata_q;
    logic                 err_q;
    logic                 cap_q;
    logic [2:0]           wr_size_q;
    logic [77:0]          wr_data_q;

    logic        accept, illegal;
    logic [38:0] w_lo, w_hi;
    logic [31:0] d_lo, d_hi, merged, enc_lo_in, enc_hi_in;
    logic        dbl_lo, dbl_hi, dbl_sel;
    logic [63:0] sel_rdata;

    assign req_ready = arm_q && (state_q == IDLE);
    assign accept    = req_valid && req_ready;

    always_comb begin
        illegal = req_size[2]
                | ((req_size[1:0] == 2'd1) && req_addr[0])
                | ((req_size[1:0] == 2'd2) && (req_addr[1:0] != 2'd0))
                | ((req_size[1:0] == 2'd3) && (req_addr[2:0] != 3'd0));
    end

    // Dword accesses are 8-byte aligned, so addr[3:2] is always the low word.
    always_comb begin
        case (addr_q[3:2])
            2'd0:    w_lo = iccm_rd_data[38:0];
            2'd1:    w_lo = iccm_rd_data[77:39];
            2'd2:    w_lo = iccm_rd_data[116:78];
            default: w_lo = iccm_rd_data[155:117];
        endcase
        w_hi = addr_q[3] ? iccm_rd_data[155:117] : iccm_rd_data[77:39];
    end

`ifdef ICCM_ACC_ECC_CHECK_EN
    assign {dbl_lo, d_lo} = ecc_fix(w_lo);
    assign {dbl_hi, d_hi} = ecc_fix(w_hi);
`else
    logic unused_ecc;
    assign d_lo       = w_lo[31:0];
    assign d_hi       = w_hi[31:0];
    assign dbl_lo     = 1'b0;
    assign dbl_hi     = 1'b0;
    assign unused_ecc = ^{w_lo[38:32], w_hi[38:32]};
`endif
    assign dbl_sel = dbl_lo | ((size_q == 3'd3) && dbl_hi);

    always_comb begin
        sel_rdata = '0;
        case (size_q[1:0])
            2'd0: begin
                case (addr_q[1:0])
                    2'd0:    sel_rdata[7:0] = d_lo[7:0];
                    2'd1:    sel_rdata[7:0] = d_lo[15:8];
                    2'd2:    sel_rdata[7:0] = d_lo[23:16];
                    default: sel_rdata[7:0] = d_lo[31:24];
                endcase
            end
            2'd1:    sel_rdata[15:0] = addr_q[1] ? d_lo[31:16] : d_lo[15:0];
            2'd2:    sel_rdata[31:0] = d_lo;
            default: sel_rdata = {d_hi, d_lo};
        endcase
    end

    always_comb begin
        merged = d_lo;
        if (size_q == 3'd0) begin
            case (addr_q[1:0])
                2'd0:    merged[7:0]   = wdata_q[7:0];
                2'd1:    merged[15:8]  = wdata_q[7:0];
                2'd2:    merged[23:16] = wdata_q[7:0];
                default: merged[31:24] = wdata_q[7:0];
            endcase
        end else if (addr_q[1]) begin
            merged[31:16] = wdata_q;
        end else begin
            merged[15:0] = wdata_q;
        end
    end

    // Two encoders shared between direct writes (encoded at acceptance) and
    // the read-modify-write merge (word replicated into both halves).
    always_comb begin
        if (state_q == IDLE) begin
            enc_lo_in = req_wdata[31:0];
            enc_hi_in = (req_size == 3'd3) ? req_wdata[63:32] : req_wdata[31:0];
        end else begin
            enc_lo_in = merged;
            enc_hi_in = merged;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (illegal)        state_d = RSP;
                    else if (!req_write) state_d = RD;
                    else if (req_size[1]) state_d = WR;
                    else                 state_d = RMW_RD;
                end
            end
            RD:      state_d = RSP;
            RMW_RD:  state_d = RMW_MRG;
            RMW_MRG: state_d = dbl_sel ? RSP : WR;
            WR:      state_d = RSP;
            RSP:     if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state_q   <= IDLE;
            arm_q     <= 1'b0;
            addr_q    <= '0;
            size_q    <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
            cap_q     <= 1'b0;
            wr_size_q <= '0;
            wr_data_q <= '0;
        end else begin
            state_q <= state_d;
            arm_q   <= 1'b1;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        addr_q    <= req_addr;
                        size_q    <= req_size;
                        wdata_q   <= req_wdata[15:0];
                        rdata_q   <= '0;
                        err_q     <= illegal;
                        cap_q     <= 1'b0;
                        wr_size_q <= (req_size == 3'd3) ? 3'd3 : 3'd2;
                        wr_data_q <= {ecc_gen(enc_hi_in), enc_hi_in,
                                      ecc_gen(enc_lo_in), enc_lo_in};
                    end
                end
                RD: cap_q <= 1'b1;
                RMW_MRG: begin
                    err_q     <= dbl_sel;
                    wr_size_q <= 3'd2;
                    wr_data_q <= {ecc_gen(enc_hi_in), enc_hi_in,
                                  ecc_gen(enc_lo_in), enc_lo_in};
                end
                RSP: begin
                    // Read data is presented live in the first response cycle
                    // and held from the register afterwards.
                    if (cap_q) begin
                        rdata_q <= sel_rdata;
                        err_q   <= err_q | dbl_sel;
                        cap_q   <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign rsp_valid    = (state_q == RSP);
    assign rsp_rdata    = rsp_valid ? (cap_q ? sel_rdata : rdata_q) : '0;
    assign rsp_err      = rsp_valid && (err_q || (cap_q && dbl_sel));
    assign iccm_rden    = (state_q == RD) || (state_q == RMW_RD);
    assign iccm_wren    = (state_q == WR);
    assign iccm_rw_addr = (iccm_rden || iccm_wren) ? addr_q[ICCM_BITS-1:2] : '0;
    assign iccm_wr_size = iccm_wren ? wr_size_q : '0;
    assign iccm_wr_data = iccm_wren ? wr_data_q : '0;

endmodule

// File: tb/tb_ifu_iccm_acc_ctl.sv
// Directed testbench for ifu_iccm_acc_ctl: write/read/RMW sequences, alignment
// errors, response back-pressure, reset during an access and, when
// ICCM_ACC_ECC_CHECK_EN is defined, single/double-bit ECC handling.
module tb_ifu_iccm_acc_ctl;

    logic         clk = 1'b0;
    logic         rst_l;
    logic         req_valid, req_write, rsp_ready;
    logic         req_ready, rsp_valid, rsp_err, iccm_wren, iccm_rden;
    logic [15:0]  req_addr;
    logic [2:0]   req_size;
    logic [63:0]  req_wdata, rsp_rdata;
    logic [13:0]  iccm_rw_addr;
    logic [2:0]   iccm_wr_size;
    logic [77:0]  iccm_wr_data;
    logic [155:0] iccm_rd_data;
    logic [38:0]  mem_w [4];

    int checks = 0;
    int errors = 0;

    assign iccm_rd_data = {mem_w[3], mem_w[2], mem_w[1], mem_w[0]};

    always #5 clk = ~clk;

    ifu_iccm_acc_ctl #(.ICCM_BITS(16)) dut (
        .clk          (clk),
        .rst_l        (rst_l),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_write    (req_write),
        .req_addr     (req_addr),
        .req_size     (req_size),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err),
        .iccm_wren    (iccm_wren),
        .iccm_rden    (iccm_rden),
        .iccm_rw_addr (iccm_rw_addr),
        .iccm_wr_size (iccm_wr_size),
        .iccm_wr_data (iccm_wr_data),
        .iccm_rd_data (iccm_rd_data)
    );

    // Check bits are the bits of the XOR of the codeword positions (3..38,
    // skipping powers of two) of all set data bits; bit 6 is overall parity.
    function automatic logic [38:0] tb_enc(input logic [31:0] d);
        logic [5:0] s;
        logic [4:0] dj;
        s  = '0;
        dj = '0;
        for (int p = 3; p < 39; p++) begin
            if ((p & (p - 1)) != 0) begin
                if (d[dj]) s = s ^ p[5:0];
                dj = dj + 5'd1;
            end
        end
        return {^{s, d}, s, d};
    endfunction

    task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic wr, input logic [15:0] a, input logic [2:0] sz,
                         input logic [63:0] wd);
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = a;
        req_size  = sz;
        req_wdata = wd;
        chk("req_ready_idle", req_ready, 1'b1);
        cyc();
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = '0;
        req_size  = '0;
        req_wdata = '0;
    endtask

    task automatic handshake();
        rsp_ready = 1'b1;
        cyc();
        rsp_ready = 1'b0;
        chk("rsp_valid_after_hs", rsp_valid, 1'b0);
        chk("req_ready_after_hs", req_ready, 1'b1);
    endtask

    initial begin
        rst_l = 1'b0;
        req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_size = '0;
        req_wdata = '0; rsp_ready = 1'b0;
        for (int i = 0; i < 4; i++) mem_w[i] = '0;

        // Reset state
        repeat (2) cyc();
        chk("rst_req_ready", req_ready, 1'b0);
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_rsp_err", rsp_err, 1'b0);
        chk("rst_en", {iccm_wren, iccm_rden}, 2'b00);
        chk("rst_rw_addr", iccm_rw_addr, 14'h0);
        chk("rst_wr_size", iccm_wr_size, 3'h0);
        chk("rst_wr_data", iccm_wr_data, 78'h0);
        chk("rst_rdata", rsp_rdata, 64'h0);
        rst_l = 1'b1;
        chk("ready_before_edge", req_ready, 1'b0);
        cyc();
        chk("ready_after_release", req_ready, 1'b1);

        // Word write 0x0040 <- 0xDEADBEEF
        issue(1'b1, 16'h0040, 3'd2, 64'h0000_0000_DEAD_BEEF);
        chk("ww_wren", {iccm_wren, iccm_rden}, 2'b10);
        chk("ww_addr", iccm_rw_addr, 14'h010);
        chk("ww_size", iccm_wr_size, 3'd2);
        chk("ww_data", iccm_wr_data, {tb_enc(32'hDEADBEEF), tb_enc(32'hDEADBEEF)});
        chk("ww_no_rsp", rsp_valid, 1'b0);
        cyc();
        chk("ww_rsp", {rsp_valid, rsp_err, iccm_wren}, 3'b100);
        chk("ww_rdata", rsp_rdata, 64'h0);
        handshake();

        // Word read back from 0x0040
        mem_w[0] = tb_enc(32'hDEADBEEF);
        mem_w[1] = tb_enc(32'h11223344);
        mem_w[2] = tb_enc(32'h0BAD0002);
        mem_w[3] = tb_enc(32'h0BAD0003);
        issue(1'b0, 16'h0040, 3'd2, 64'h0);
        chk("wr_rden", {iccm_wren, iccm_rden, rsp_valid}, 3'b010);
        chk("wr_addr", iccm_rw_addr, 14'h010);
        cyc();
        chk("wr_rsp", {rsp_valid, rsp_err, iccm_rden}, 3'b100);
        chk("wr_rdata", rsp_rdata, 64'h0000_0000_DEAD_BEEF);
        handshake();

        // Byte write 0x0045 <- 0xA5 over 0x11223344
        issue(1'b1, 16'h0045, 3'd0, 64'h0000_0000_0000_00A5);
        chk("bw_c1_rden", {iccm_wren, iccm_rden}, 2'b01);
        chk("bw_c1_addr", iccm_rw_addr, 14'h011);
        cyc();
        chk("bw_c2_idle_en", {iccm_wren, iccm_rden, rsp_valid}, 3'b000);
        cyc();
        chk("bw_c3_wren", {iccm_wren, iccm_rden, rsp_valid}, 3'b100);
        chk("bw_c3_addr", iccm_rw_addr, 14'h011);
        chk("bw_c3_size", iccm_wr_size, 3'd2);
        chk("bw_c3_data", iccm_wr_data, {tb_enc(32'h1122A544), tb_enc(32'h1122A544)});
        cyc();
        chk("bw_c4_rsp", {rsp_valid, rsp_err, iccm_wren}, 3'b100);
        chk("bw_rdata", rsp_rdata, 64'h0);
        handshake();

        // Dword read at 0x0008 with back-pressure for 3 cycles
        issue(1'b0, 16'h0008, 3'd3, 64'h0);
        chk("dr_rden", iccm_rden, 1'b1);
        chk("dr_addr", iccm_rw_addr, 14'h002);
        cyc();
        chk("dr_rsp", {rsp_valid, rsp_err}, 2'b10);
        chk("dr_rdata", rsp_rdata, 64'h0BAD0003_0BAD0002);
        cyc();
        mem_w[2] = '0;
        mem_w[3] = '0;
        chk("dr_hold1", {rsp_valid, rsp_rdata}, {1'b1, 64'h0BAD0003_0BAD0002});
        cyc();
        chk("dr_hold2", {rsp_valid, rsp_rdata}, {1'b1, 64'h0BAD0003_0BAD0002});
        handshake();

        // Half read 0x0006 and byte read 0x0007 from word 0x11223344
        issue(1'b0, 16'h0006, 3'd1, 64'h0);
        cyc();
        chk("hr_rdata", {rsp_valid, rsp_rdata}, {1'b1, 64'h0000_0000_0000_1122});
        handshake();
        issue(1'b0, 16'h0007, 3'd0, 64'h0);
        cyc();
        chk("br_rdata", {rsp_valid, rsp_rdata}, {1'b1, 64'h0000_0000_0000_0011});
        handshake();

        // Dword write 0x0018
        issue(1'b1, 16'h0018, 3'd3, 64'h0123_4567_89AB_CDEF);
        chk("dw_wren", {iccm_wren, iccm_rden}, 2'b10);
        chk("dw_addr", iccm_rw_addr, 14'h006);
        chk("dw_size", iccm_wr_size, 3'd3);
        chk("dw_data", iccm_wr_data, {tb_enc(32'h01234567), tb_enc(32'h89ABCDEF)});
        cyc();
        chk("dw_rsp", {rsp_valid, rsp_err}, 2'b10);
        handshake();

        // Misaligned / illegal requests: response one cycle after acceptance
        issue(1'b0, 16'h0042, 3'd2, 64'h0);
        chk("mis_word", {rsp_valid, rsp_err, iccm_wren, iccm_rden}, 4'b1100);
        handshake();
        issue(1'b1, 16'h0041, 3'd1, 64'h0);
        chk("mis_half", {rsp_valid, rsp_err, iccm_wren, iccm_rden}, 4'b1100);
        handshake();
        issue(1'b0, 16'h000C, 3'd3, 64'h0);
        chk("mis_dword", {rsp_valid, rsp_err, iccm_wren, iccm_rden}, 4'b1100);
        handshake();
        issue(1'b0, 16'h0000, 3'd5, 64'h0);
        chk("bad_size", {rsp_valid, rsp_err, iccm_wren, iccm_rden}, 4'b1100);
        handshake();

        // Reset pulse during RMW_RD abandons the access
        issue(1'b1, 16'h0045, 3'd0, 64'h0000_0000_0000_00A5);
        chk("rr_rden", iccm_rden, 1'b1);
        rst_l = 1'b0;
        #1;
        chk("rr_rst_en", {iccm_wren, iccm_rden, rsp_valid}, 3'b000);
        cyc();
        rst_l = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("rr_quiet", {iccm_wren, iccm_rden, rsp_valid}, 3'b000);
            chk("rr_ready", req_ready, 1'b1);
        end
        issue(1'b0, 16'h0040, 3'd2, 64'h0);
        cyc();
        chk("rr_resume", {rsp_valid, rsp_rdata}, {1'b1, 64'h0000_0000_DEAD_BEEF});
        handshake();

`ifdef ICCM_ACC_ECC_CHECK_EN
        mem_w[0] = tb_enc(32'hDEADBEEF) ^ 39'h20;
        issue(1'b0, 16'h0040, 3'd2, 64'h0);
        cyc();
        chk("ecc_sbe", {rsp_valid, rsp_err, rsp_rdata}, {2'b10, 64'h0000_0000_DEAD_BEEF});
        handshake();
        mem_w[0] = tb_enc(32'hDEADBEEF) ^ 39'h220;
        issue(1'b0, 16'h0040, 3'd2, 64'h0);
        cyc();
        chk("ecc_dbe", {rsp_valid, rsp_err}, 2'b11);
        handshake();
        issue(1'b1, 16'h0041, 3'd0, 64'h0000_0000_0000_0077);
        cyc();
        cyc();
        chk("ecc_rmw_dbe", {rsp_valid, rsp_err, iccm_wren}, 3'b110);
        handshake();
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ifu_iccm_acc_ctl.md
IFU_ICCM_ACC_CTL -- requirements
Module: ifu_iccm_acc_ctl

Interface
REQ-001 Parameter: ICCM_BITS, default 16, ICCM byte-address width.
REQ-002 Ports (name  direction  width  meaning):
- clk  in  1  clock; one clock only.
- rst_l  in  1  reset; asynchronous, active-low.
- req_valid  in  1  access request valid.
- req_ready  out  1  controller can accept a request.
- req_write  in  1  1 = write, 0 = read.
- req_addr  in  ICCM_BITS  byte address.
- req_size  in  3  0 = byte, 1 = half, 2 = word, 3 = dword.
- req_wdata  in  64  write data, right-justified.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response accepted.
- rsp_rdata  out  64  read data.
- rsp_err  out  1  response error.
- iccm_wren  out  1  ICCM write enable.
- iccm_rden  out  1  ICCM read enable.
- iccm_rw_addr  out  ICCM_BITS-2  ICCM word address [ICCM_BITS-1:2].
- iccm_wr_size  out  3  ICCM write size.
- iccm_wr_data  out  78  two 39-bit ECC words: [38:0] even word, [77:39] odd word.
- iccm_rd_data  in  156  four 39-bit words, one cycle after rden: [38:0] addr[3:2]=0, [77:39] =1, [116:78] =2, [155:117] =3.

Function
REQ-003 FSM states: IDLE, RD, RMW_RD, RMW_MRG, WR, RSP.
REQ-004 req_ready = 1 only in IDLE; a request is accepted on req_valid & req_ready, and its address, size, write and data are registered on acceptance.
REQ-005 Misaligned or illegal requests go IDLE->RSP with rsp_err=1 and no ICCM enable asserted:
- size 1 with addr[0]=1
- size 2 with addr[1:0]!=0
- size 3 with addr[2:0]!=0
- size >3
REQ-006 Aligned read: IDLE->RD. RD asserts iccm_rden for exactly one cycle, then goes to RSP. The cycle after RD, iccm_rd_data is captured into the response register.
REQ-007 Read data selection:
- dword: {word[addr[3]*2+1], word[addr[3]*2]}.
- word: selected word, zero-extended.
- byte/half: selected bytes, right-justified, zero-extended.
- Only bits [31:0] of each 39-bit word are returned.
REQ-008 Word/dword write: IDLE->WR. WR asserts iccm_wren for one cycle, then goes to RSP.
- size 3: iccm_wr_size=3, wr_data={enc(wdata[63:32]), enc(wdata[31:0])}.
- size 2: iccm_wr_size=2, the encoded word is replicated in both halves.
REQ-009 Byte/half write (read-modify-write): IDLE->RMW_RD (rden, one cycle)->RMW_MRG (capture the word, merge the new bytes, re-encode)->WR (wren, iccm_wr_size=2)->RSP.
REQ-010 enc() is the codebase 7-bit SECDED encoding over 32 data bits.
REQ-011 iccm_rw_addr equals the registered req_addr[ICCM_BITS-1:2] in RD, RMW_RD and WR, and is 0 elsewhere.
REQ-012 iccm_wren and iccm_rden are never asserted in the same cycle.
REQ-013 RSP: rsp_valid=1 until rsp_ready; then go to IDLE. The next request can be accepted the cycle after the handshake. rsp_rdata=0 for writes.
REQ-014 Latency, acceptance to rsp_valid: read 2 cycles; word/dword write 2; byte/half write 4; error 1.
REQ-015 rsp_valid is never asserted without a preceding accepted request.

Reset
REQ-016 While rst_l=0: state=IDLE, and req_ready, rsp_valid, rsp_err, iccm_wren, iccm_rden, iccm_rw_addr, iccm_wr_size, iccm_wr_data and rsp_rdata are all 0.
REQ-017 Reset asserted mid-operation abandons the access: no further enable is asserted and no response is issued; operation resumes from IDLE on release.
REQ-018 req_ready rises the first clk edge after rst_l deasserts.

Configuration
REQ-019 Macro ICCM_ACC_ECC_CHECK_EN, when defined, enables SECDED check on every captured word (RD, RMW_MRG):
- single-bit error: corrected data is used, rsp_err=0.
- double-bit error: rsp_err=1. In an RMW the write is suppressed (RMW_MRG->RSP).
REQ-020 Without ICCM_ACC_ECC_CHECK_EN: the ECC bits of captured words are ignored, rsp_err is set only by REQ-005, and writes still generate ECC.

Verification
REQ-021 Word write 0x0040, data 0xDEADBEEF, then read back:
- write: iccm_wren for one cycle, rw_addr=0x010, wr_size=2, both halves=enc(0xDEADBEEF).
- read: rsp_rdata=0x00000000DEADBEEF, rsp_err=0.
REQ-022 Byte write 0x0045 data 0xA5 over stored word 0x11223344: rden cycle, then wren cycle with merged 0x1122A544; rsp at cycle 4.
REQ-023 Dword read at 0x0008 with words 2,3 = 0x0BAD0002, 0x0BAD0003 -> rsp_rdata=0x0BAD00030BAD0002.
REQ-024 Word request at 0x0042 -> rsp_err=1 one cycle after acceptance; iccm_wren/rden remain 0.
REQ-025 ECC with ICCM_ACC_ECC_CHECK_EN defined:
- flip bit 5 of the stored word -> corrected data returned, rsp_err=0.
- flip bits 5 and 9 -> rsp_err=1.
REQ-026 rsp_ready held low 3 cycles -> rsp_valid and rsp_rdata stable; rst_l pulsed low during RMW_RD -> no wren, no rsp_valid, IDLE after release.
